// File: rtl/data_memory_unit_pkg.sv
// data_memory_unit_pkg: shared widths, memory map and decode select type
package data_memory_unit_pkg;
  localparam int ADDR = 16;
  localparam int W_OPR = 32;
  localparam int W_CON = 8;
  localparam int DEPTH_LOG2 = 12;
  localparam int CON_DEPTH_LOG2 = 2;
  localparam logic [ADDR-1:0] CON_ADDR = 16'hFFFF;
  localparam logic [ADDR-1:0] CNT_ADDR = 16'hFFFE;
  typedef enum logic [1:0] {SEL_RAM, SEL_CON, SEL_CNT, SEL_OOR} sel_t;
endpackage

// File: rtl/data_memory_unit_console_fifo.sv
// console_fifo: synchronous push/pop FIFO with occupancy count
module console_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  logic [W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign full = count[DEPTH_LOG2];
  assign empty = count == '0;
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: data RAM plus memory-mapped console FIFO and cycle counter
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int ADDR = data_memory_unit_pkg::ADDR,
  parameter int W_OPR = data_memory_unit_pkg::W_OPR,
  parameter int DEPTH_LOG2 = data_memory_unit_pkg::DEPTH_LOG2,
  parameter int CON_DEPTH_LOG2 = data_memory_unit_pkg::CON_DEPTH_LOG2,
  parameter logic [ADDR-1:0] CON_ADDR = data_memory_unit_pkg::CON_ADDR,
  parameter logic [ADDR-1:0] CNT_ADDR = data_memory_unit_pkg::CNT_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDR-1:0]  addr_i,
  input  logic             write_i,
  input  logic [W_OPR-1:0] data_i,
  output logic [W_OPR-1:0] data_o,
  output logic             stall_o,
  output logic             con_valid_o,
  output logic [W_CON-1:0] con_data_o,
  input  logic             con_ready_i,
  output logic             err_o
);
  logic [W_OPR-1:0] mem [2**DEPTH_LOG2];
  logic [W_OPR-1:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [CON_DEPTH_LOG2:0] con_count;
  logic con_full, con_empty, push, pop;
  sel_t sel;
  assign idx = addr_i[DEPTH_LOG2-1:0];
  assign sel = addr_i == CON_ADDR ? SEL_CON :
               addr_i == CNT_ADDR ? SEL_CNT :
               addr_i[ADDR-1:DEPTH_LOG2] == '0 ? SEL_RAM : SEL_OOR;
  assign stall_o = write_i & (sel == SEL_CON) & con_full;
  assign push = write_i & (sel == SEL_CON) & ~con_full;
  assign pop = ~con_empty & con_ready_i;
  assign con_valid_o = ~con_empty;
  always_ff @(posedge clk)
    if (write_i && sel == SEL_RAM) mem[idx] <= data_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_o <= '0;
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      data_o <= write_i ? mem[idx] :
                sel == SEL_CON ? W_OPR'({con_full, con_count}) :
                sel == SEL_CNT ? cnt :
                sel == SEL_RAM ? mem[idx] : '0;
      cnt <= (write_i && sel == SEL_CNT) ? data_i : cnt + 1'b1;
      err_o <= err_o | (sel == SEL_OOR);
    end
  console_fifo #(.DEPTH_LOG2(CON_DEPTH_LOG2), .W(W_CON)) u_con (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(data_i[W_CON-1:0]),
    .dout(con_data_o),
    .full(con_full),
    .empty(con_empty),
    .count(con_count)
  );
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed self-checking bench for data_memory_unit
module tb_data_memory_unit;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] addr_i;
  logic write_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic stall_o, con_valid_o, con_ready_i, err_o;
  logic [7:0] con_data_o;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  data_memory_unit dut (
    .clk(clk),
    .reset(reset),
    .addr_i(addr_i),
    .write_i(write_i),
    .data_i(data_i),
    .data_o(data_o),
    .stall_o(stall_o),
    .con_valid_o(con_valid_o),
    .con_data_o(con_data_o),
    .con_ready_i(con_ready_i),
    .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic [15:0] a, input logic [31:0] d);
    write_i = w;
    addr_i = a;
    data_i = d;
    #1;
  endtask
  initial begin
    reset = 1'b0;
    con_ready_i = 1'b0;
    drive(1'b0, 16'h0010, 32'h0);
    #11;
    chk("rst_data", data_o, 32'h0);
    chk("rst_valid", {31'b0, con_valid_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick;
    drive(1'b1, 16'h0010, 32'hDEADBEEF);
    tick;
    drive(1'b0, 16'h0010, 32'h0);
    tick;
    chk("ram_load", data_o, 32'hDEADBEEF);
    drive(1'b1, 16'h0020, 32'hAAAA5555);
    tick;
    drive(1'b1, 16'h0020, 32'h00001234);
    tick;
    chk("ram_read_first", data_o, 32'hAAAA5555);
    drive(1'b0, 16'h0020, 32'h0);
    tick;
    chk("ram_new", data_o, 32'h00001234);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hFFFF, 32'h41 + 32'(i));
      chk("con_nostall", {31'b0, stall_o}, 32'h0);
      tick;
      chk("con_head_a", {24'b0, con_data_o}, 32'h41);
    end
    drive(1'b0, 16'hFFFF, 32'h0);
    tick;
    chk("con_status_full", data_o, 32'h0000000C);
    drive(1'b1, 16'hFFFF, 32'h45);
    chk("stall_e", {31'b0, stall_o}, 32'h1);
    tick;
    chk("stall_e_hold", {31'b0, stall_o}, 32'h1);
    con_ready_i = 1'b1;
    #1;
    chk("stall_during_pop", {31'b0, stall_o}, 32'h1);
    tick;
    con_ready_i = 1'b0;
    #1;
    chk("head_b", {24'b0, con_data_o}, 32'h42);
    chk("stall_released", {31'b0, stall_o}, 32'h0);
    tick;
    drive(1'b1, 16'hFFFF, 32'h46);
    con_ready_i = 1'b1;
    #1;
    chk("stall_full_pop", {31'b0, stall_o}, 32'h1);
    tick;
    con_ready_i = 1'b0;
    #1;
    chk("head_c", {24'b0, con_data_o}, 32'h43);
    chk("f_retry_nostall", {31'b0, stall_o}, 32'h0);
    tick;
    drive(1'b0, 16'hFFFF, 32'h0);
    tick;
    chk("count_back_4", data_o, 32'h0000000C);
    drive(1'b0, 16'h0010, 32'h0);
    con_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, con_valid_o}, 32'h1);
      chk("drain_order", {24'b0, con_data_o}, 32'h43 + 32'(i));
      tick;
    end
    con_ready_i = 1'b0;
    chk("drain_empty", {31'b0, con_valid_o}, 32'h0);
    drive(1'b1, 16'hFFFF, 32'h47);
    tick;
    chk("g_visible", {24'b0, con_data_o}, 32'h47);
    drive(1'b1, 16'hFFFF, 32'h48);
    con_ready_i = 1'b1;
    tick;
    con_ready_i = 1'b0;
    drive(1'b0, 16'hFFFF, 32'h0);
    chk("pushpop_head", {24'b0, con_data_o}, 32'h48);
    tick;
    chk("pushpop_count", data_o, 32'h00000001);
    drive(1'b1, 16'hFFFE, 32'hFFFFFFFE);
    tick;
    drive(1'b0, 16'h0010, 32'h0);
    tick;
    drive(1'b0, 16'hFFFE, 32'h0);
    tick;
    chk("cnt_load", data_o, 32'hFFFFFFFF);
    tick;
    chk("cnt_wrap", data_o, 32'h0);
    drive(1'b1, 16'h0000, 32'h11112222);
    tick;
    drive(1'b0, 16'h0010, 32'h0);
    chk("err_clear", {31'b0, err_o}, 32'h0);
    drive(1'b0, 16'h2000, 32'h0);
    tick;
    chk("oor_data", data_o, 32'h0);
    chk("oor_err", {31'b0, err_o}, 32'h1);
    drive(1'b1, 16'h2000, 32'hBADBAD00);
    tick;
    drive(1'b0, 16'h0000, 32'h0);
    tick;
    chk("oor_store_dropped", data_o, 32'h11112222);
    chk("err_sticky", {31'b0, err_o}, 32'h1);
    drive(1'b1, 16'hFFFF, 32'h49);
    tick;
    drive(1'b1, 16'hFFFF, 32'h4A);
    tick;
    drive(1'b0, 16'h0010, 32'h0);
    tick;
    chk("pre_rst_data", data_o, 32'hDEADBEEF);
    con_ready_i = 1'b1;
    tick;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", {31'b0, con_valid_o}, 32'h0);
    chk("rst_mid_err", {31'b0, err_o}, 32'h0);
    chk("rst_mid_data", data_o, 32'h0);
    con_ready_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 16'hFFFE, 32'h0);
    tick;
    chk("cnt_after_rst", data_o, 32'h0);
    drive(1'b0, 16'hFFFF, 32'h0);
    tick;
    chk("status_after_rst", data_o, 32'h0);
    drive(1'b1, 16'hFFFF, 32'h4B);
    chk("stall_after_rst", {31'b0, stall_o}, 32'h0);
    tick;
    chk("push_after_rst", {24'b0, con_data_o}, 32'h4B);
    drive(1'b0, 16'h0010, 32'h0);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
